// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and line levels for the piso_tx serial framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // Frame phases of the transmitter
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Serial line levels
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_tx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_timer
//  Description : Free-running bit-period counter. tick marks the last clock
//                of a bit period; pre_tick says the next clock will be that
//                last clock, so registered outputs can line up with tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Count 0..CLKS_PER_BIT-1 and wrap; clr realigns to the start of a period
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

  // Look-ahead: with one clock per bit every clock is the last one
  generate
    if (CLKS_PER_BIT == 1) begin : g_every_cycle
      assign pre_tick = 1'b1;
    end else begin : g_multi_cycle
      localparam logic [CW-1:0] PRE = CW'(CLKS_PER_BIT - 2);
      assign pre_tick = !clr && (count == PRE);
    end
  endgenerate

endmodule : bit_timer
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx
//  Description : Parallel-in/serial-out framed transmitter. Frame is start
//                bit, data LSB first, even parity, stop bit. Word accepted
//                over a valid/ready handshake; back-to-back frames allowed.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] shift, shift_d;
  logic             parity, parity_d;
  logic [BCW-1:0]   bit_cnt, bit_cnt_d;
  logic             sout_d, busy_d, done_d;
  logic             tick, pre_tick, xfer;

  // Ready in IDLE, or in the last clock of STOP so frames can abut
  assign din_ready = (state == IDLE) || ((state == STOP) && tick);
  assign xfer      = din_valid && din_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (xfer),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and next-output decode; sout is computed one clock ahead
  always_comb begin
    state_d   = state;
    shift_d   = shift;
    parity_d  = parity;
    bit_cnt_d = bit_cnt;
    sout_d    = sout;
    case (state)
      IDLE: begin
        sout_d = IDLE_LEVEL;
        if (xfer) begin
          state_d  = START;
          shift_d  = din;
          parity_d = ^din;
          sout_d   = START_LEVEL;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          sout_d    = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift >> 1;
          if (bit_cnt == LAST_BIT) begin
            state_d = PARITY;
            sout_d  = parity;
          end else begin
            bit_cnt_d = bit_cnt + BCW'(1);
            sout_d    = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          sout_d  = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (tick) begin
          if (xfer) begin
            state_d  = START;
            shift_d  = din;
            parity_d = ^din;
            sout_d   = START_LEVEL;
          end else begin
            state_d = IDLE;
            sout_d  = IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sout_d  = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && pre_tick;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
      sout    <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      shift   <= shift_d;
      parity  <= parity_d;
      bit_cnt <= bit_cnt_d;
      sout    <= sout_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule : piso_tx
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_tx
//  Description : Self-checking bench for piso_tx; one instance at one clock
//                per bit, one at four clocks per bit. Expected serial bits
//                are queued when a word is sent and popped per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] din_a, din_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       sout_a, sout_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int errors = 0;
  int checks = 0;

  logic q_a[$];
  logic q_b[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_a (
    .clk(clk), .rstn(rstn), .din(din_a), .din_valid(valid_a),
    .din_ready(ready_a), .sout(sout_a), .busy(busy_a), .done(done_a)
  );

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_b (
    .clk(clk), .rstn(rstn), .din(din_b), .din_valid(valid_b),
    .din_ready(ready_b), .sout(sout_b), .busy(busy_b), .done(done_b)
  );

  // Expected line image of one frame, each bit repeated reps times
  function automatic void push_frame(input logic [7:0] w, input int reps, input bit to_b);
    logic bits[11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = w[i];
    bits[9]  = ^w;
    bits[10] = 1'b1;
    for (int i = 0; i < 11; i++)
      for (int r = 0; r < reps; r++)
        if (to_b) q_b.push_back(bits[i]);
        else      q_a.push_back(bits[i]);
  endfunction

  task automatic test_reset();
    rstn = 1'b0; valid_a = 1'b1; valid_b = 1'b1; din_a = 8'hFF; din_b = 8'h81;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({sout_a, busy_a, done_a, ready_a} !== 4'b1001) begin
        errors++;
        $display("FAIL reset_a cyc%0d sout/busy/done/ready=%b%b%b%b expected 1001", c, sout_a, busy_a, done_a, ready_a);
      end
      checks++;
      if ({sout_b, busy_b, done_b, ready_b} !== 4'b1001) begin
        errors++;
        $display("FAIL reset_b cyc%0d sout/busy/done/ready=%b%b%b%b expected 1001", c, sout_b, busy_b, done_b, ready_b);
      end
    end
    valid_a = 1'b0; valid_b = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sout_a, busy_a, sout_b, busy_b} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_no_xfer sout_a/busy_a/sout_b/busy_b=%b%b%b%b expected 1010", sout_a, busy_a, sout_b, busy_b);
    end
  endtask

  task automatic test_single(input logic [7:0] w);
    logic exp;
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL single_%h_ready got %b expected 1", w, ready_a);
    end
    din_a = w; valid_a = 1'b1;
    push_frame(w, 1, 1'b0);
    @(posedge clk); #1;
    valid_a = 1'b0; din_a = 8'($urandom);
    for (int i = 0; i < 11; i++) begin
      exp = q_a.pop_front();
      checks++;
      if (sout_a !== exp) begin
        errors++;
        $display("FAIL single_%h_sout cyc%0d got %b expected %b", w, i + 1, sout_a, exp);
      end
      checks++;
      if (done_a !== (i == 10)) begin
        errors++;
        $display("FAIL single_%h_done cyc%0d got %b expected %b", w, i + 1, done_a, (i == 10));
      end
      checks++;
      if (busy_a !== 1'b1) begin
        errors++;
        $display("FAIL single_%h_busy cyc%0d got %b expected 1", w, i + 1, busy_a);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({busy_a, done_a, sout_a} !== 3'b001) begin
      errors++;
      $display("FAIL single_%h_end busy/done/sout=%b%b%b expected 001", w, busy_a, done_a, sout_a);
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    int   dones = 0;
    din_a = 8'h01; valid_a = 1'b1;
    push_frame(8'h01, 1, 1'b0);
    push_frame(8'h02, 1, 1'b0);
    @(posedge clk); #1;
    din_a = 8'h02;
    for (int i = 0; i < 22; i++) begin
      exp = q_a.pop_front();
      checks++;
      if (sout_a !== exp) begin
        errors++;
        $display("FAIL b2b_sout cyc%0d got %b expected %b", i + 1, sout_a, exp);
      end
      checks++;
      if (busy_a !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy cyc%0d got %b expected 1", i + 1, busy_a);
      end
      if (done_a === 1'b1) dones++;
      if (i == 10) begin
        checks++;
        if (ready_a !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_stop got %b expected 1", ready_a);
        end
      end
      @(posedge clk); #1;
      if (i == 10) valid_a = 1'b0;
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d expected 2", dones);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end_busy got %b expected 0", busy_a);
    end
  endtask

  task automatic test_slow_bits();
    logic exp;
    int   dones = 0;
    din_b = 8'hA5; valid_b = 1'b1;
    push_frame(8'hA5, 4, 1'b1);
    @(posedge clk); #1;
    valid_b = 1'b0;
    for (int i = 0; i < 44; i++) begin
      exp = q_b.pop_front();
      checks++;
      if (sout_b !== exp) begin
        errors++;
        $display("FAIL slow_sout cyc%0d got %b expected %b", i + 1, sout_b, exp);
      end
      checks++;
      if (done_b !== (i == 43)) begin
        errors++;
        $display("FAIL slow_done cyc%0d got %b expected %b", i + 1, done_b, (i == 43));
      end
      if (done_b === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL slow_end dones=%0d busy=%b expected 1 and 0", dones, busy_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    din_a = 8'hA5; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    // cycle 1 is the start bit; data bit 4 is on the line in cycle 6
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sout_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_bit4 got %b expected 0", sout_a);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({sout_a, busy_a, done_a} !== 3'b100) begin
      errors++;
      $display("FAIL midrst_async sout/busy/done=%b%b%b expected 100", sout_a, busy_a, done_a);
    end
    q_a.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sout_a, busy_a, done_a} !== 3'b100) begin
      errors++;
      $display("FAIL midrst_after sout/busy/done=%b%b%b expected 100", sout_a, busy_a, done_a);
    end
    test_single(8'h3C);
  endtask

  initial begin
    rstn = 1'b0; valid_a = 1'b0; valid_b = 1'b0; din_a = '0; din_b = '0;
    test_reset();
    test_single(8'hA5);
    test_single(8'h07);
    test_single(8'h00);
    test_back_to_back();
    test_slow_bits();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before test sequence completed");
    $fatal(1);
  end

endmodule : tb_piso_tx
`default_nettype wire
